// File: rtl/imem_line_if.sv
// Request/response bundle between the icache lower port and the line responder.
// Latency: none, wires only.
// Backpressure: req_ready_o / res_ready_i carry the valid-ready handshakes.
interface imem_line_if #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [XLEN-1:0]     req_addr_i;
  logic                req_uncached_i;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [BLK_SIZE-1:0] res_blk_o;
  logic                err_o;

  // Fetch side: issues requests, consumes responses.
  modport master (
    output req_valid_i, req_addr_i, req_uncached_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_blk_o, err_o
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid_i, req_addr_i, req_uncached_i, res_ready_i,
    output req_ready_o, res_valid_o, res_blk_o, err_o
  );
endinterface

// File: rtl/imem_line_responder.sv
// Instruction line-fill responder: reads a BLK_SIZE line (or one word) from the SRAM.
// Latency: accept to res_valid_o is 6 cycles cached, 3 uncached, 1 for an address fault.
// Backpressure: one request in flight; response held stable until res_ready_i, req_ready_o low meanwhile.
module imem_line_responder #(
  parameter int              XLEN      = 32,
  parameter int              BLK_SIZE  = 128,
  parameter int              MEM_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h4000_0000,
  localparam int             AW        = $clog2(MEM_WORDS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  imem_line_if.slave      bus,
  output logic            mem_en_o,
  output logic [AW-1:0]   mem_addr_o,
  input  logic [XLEN-1:0] mem_rdata_i
);
  localparam int BEATS = BLK_SIZE / XLEN;
  localparam int LW    = $clog2(BEATS);
  localparam int CW    = LW + 1;
  localparam logic [CW-1:0] N_BEATS  = CW'(BEATS);
  localparam logic [CW-1:0] LAST_CAP = CW'(BEATS - 1);
  // Window bounds one bit wider than the address so the end cannot wrap.
  localparam logic [XLEN:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [XLEN:0] WIN_HI = WIN_LO + ((XLEN+1)'(MEM_WORDS) << 2);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       word_idx_q;
  logic [LW-1:0]       lane_q;
  logic                unc_q;
  logic [CW-1:0]       issue_cnt_q;
  logic [CW-1:0]       cap_cnt_q;
  logic                pend_q;
  logic [BLK_SIZE-1:0] blk_q;
  logic                err_q;

  logic                accept;
  logic                in_range;
  logic                issue_vld;
  logic                last_cap;
  logic [LW-1:0]       cap_lane;
  logic [XLEN-1:0]     off;
  logic [XLEN:0]       addr_x;
  logic                unused_off_bits;

  assign addr_x          = {1'b0, bus.req_addr_i};
  assign in_range        = (addr_x >= WIN_LO) && (addr_x < WIN_HI);
  assign off             = bus.req_addr_i - BASE_ADDR;
  assign unused_off_bits = ^{off[XLEN-1:AW+2], off[1:0]};
  assign accept          = (state_q == IDLE) && bus.req_valid_i && !rst_i;
  assign issue_vld       = (state_q == READ) && (issue_cnt_q < (unc_q ? CW'(1) : N_BEATS));
  assign last_cap        = (state_q == READ) && pend_q && (unc_q || (cap_cnt_q == LAST_CAP));
  assign cap_lane        = unc_q ? lane_q : cap_cnt_q[LW-1:0];

  assign bus.res_blk_o   = blk_q;
  assign bus.err_o       = err_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake/SRAM strobes; reads are issued straight from the counter.
  always_comb begin
    state_d         = state_q;
    bus.req_ready_o = 1'b0;
    bus.res_valid_o = 1'b0;
    mem_en_o        = 1'b0;
    mem_addr_o      = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = !rst_i;
        if (accept) state_d = in_range ? READ : RESP;
      end
      READ: begin
        if (issue_vld) begin
          mem_en_o   = 1'b1;
          mem_addr_o = unc_q ? word_idx_q : {word_idx_q[AW-1:LW], issue_cnt_q[LW-1:0]};
        end
        if (last_cap) state_d = RESP;
      end
      RESP: begin
        bus.res_valid_o = 1'b1;
        if (bus.res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counters and lane capture; pend_q marks read data due this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_idx_q  <= '0;
      lane_q      <= '0;
      unc_q       <= 1'b0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      pend_q      <= 1'b0;
      blk_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      pend_q <= issue_vld;
      if (accept) begin
        word_idx_q  <= off[AW+1:2];
        lane_q      <= bus.req_addr_i[LW+1:2];
        unc_q       <= bus.req_uncached_i;
        issue_cnt_q <= '0;
        cap_cnt_q   <= '0;
        blk_q       <= '0;
        err_q       <= !in_range;
      end
      if (issue_vld) issue_cnt_q <= issue_cnt_q + 1'b1;
      if ((state_q == READ) && pend_q) begin
        blk_q[cap_lane*XLEN +: XLEN] <= mem_rdata_i;
        cap_cnt_q                    <= cap_cnt_q + 1'b1;
      end
    end
  end
endmodule
